pix_stream_tx: RTL and testbench
================================

Name: pix_stream_tx

Overview:
Frame-buffer reader and pixel-stream transmitter. It drives the framed pixel interface consumed by the convolution line-buffer front end: ima, ena, frame_start, line_start and frame_end. The block reads a raster image out of a synchronous-read SRAM port, one pixel per beat, with optional back-pressure (stall) and programmable horizontal blanking. It sits between the image store and the conv input window builder.

Parameters:
IMA, 8, pixel width in bits
IMG_W, 32, pixels per line (>=2)
IMG_H, 32, lines per frame (>=2)
HBLANK, 2, idle cycles inserted between lines (0 allowed)
ADDR_W, 10, SRAM address width; 2**ADDR_W >= IMG_W*IMG_H

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request one frame; sampled only in IDLE
stall  in  1  when high, no pixel read is issued this cycle
mem_rd  out  1  SRAM read strobe
mem_addr  out  ADDR_W  SRAM read address; data returns next cycle
mem_data  in  IMA  SRAM read data, valid 1 cycle after mem_rd
ima  out  IMA  pixel; holds last value when ena_out=0
ena_out  out  1  pixel valid
frame_start_out  out  1  1-cycle pulse, one cycle before first pixel, ena_out=0
line_start_out  out  1  high with the first pixel of each line
frame_end_out  out  1  high with the last pixel of the frame
busy  out  1  frame in progress
done  out  1  1-cycle pulse the cycle after frame_end_out

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. In reset, state=IDLE, col/row/addr/blank counters=0, and all outputs=0, including ima and mem_addr.
- Reset mid-frame aborts the frame immediately. No frame_end_out or done is produced. After release, the block waits in IDLE.
- FSM states:
  - IDLE: busy=0. start=1 -> FSTART.
  - FSTART: one cycle. Loads a frame-start tag into the output pipe; mem_rd=0. -> ACTIVE; col=row=addr=0.
  - ACTIVE: if stall=0, then mem_rd=1 and mem_addr=addr. The beat tag is line_start=(col==0) and frame_end=(col==IMG_W-1 && row==IMG_H-1). Then addr++ and col++.
    - At col==IMG_W-1: col resets to 0. If row==IMG_H-1 -> DONE. Otherwise row++ and go to HBLANK, or stay in ACTIVE if HBLANK==0.
    - If stall=1: nothing is issued and counters hold.
  - HBLANK: counts HBLANK cycles with mem_rd=0, ignoring stall. -> ACTIVE.
  - DONE: one cycle. -> IDLE.
- Output pipe: one register stage aligned to SRAM latency. ena_out, line_start_out and frame_end_out equal the previous cycle's issue tag. ima<=mem_data when the tag is valid. frame_start_out = previous cycle was FSTART.
- Stall-to-output latency is exactly 1 cycle. A stall in cycle t gives ena_out=0 in cycle t+1. Stall never drops or duplicates a pixel.
- done is registered: it is high in the cycle after frame_end_out.
- busy = (state!=IDLE) || pipe valid. busy falls in the same cycle done rises.
- start while busy is ignored, including start during DONE. start held high continuously gives back-to-back frames with exactly one IDLE cycle between done and the next FSTART.
- Timing, no stall: start sampled at edge k. frame_start_out is high in cycle k+2 and the first pixel arrives in cycle k+3. frame_end_out is in cycle k+3+IMG_W*IMG_H-1+(IMG_H-1)*HBLANK.
- mem_addr is a linear counter. It restarts at 0 every frame and never wraps within a frame.
- Flags are never simultaneous: frame_start_out never coincides with ena_out. line_start_out and frame_end_out are only high when ena_out=1.

Test Plan:
- IMG_W=4, IMG_H=3, HBLANK=2, mem_data=addr, start at edge k -> frame_start_out in cycle k+2. Pixels 0..11 arrive in order, with line_start_out on pixels 0, 4 and 8. Two-cycle gaps after pixels 3 and 7. frame_end_out with pixel 11 in cycle k+18, done in k+19, 12 ena_out beats total.
- Same config, stall high for 3 cycles mid-line 1 -> ena_out low for exactly 3 cycles, one cycle after stall. Pixel sequence unchanged, frame_end_out shifted to k+21.
- HBLANK=0 -> 12 contiguous beats in cycles k+3..k+14. frame_end_out in k+14.
- start pulsed again at k+10 (busy) -> ignored; exactly one frame produced. start held high -> second frame_start_out 3 cycles after first done, i.e. done, IDLE, FSTART, pulse.
- rst_n asserted during line 2 -> all outputs 0 asynchronously, no frame_end_out or done. After release and a new start, the frame restarts at addr 0.
- Default params (32x32, HBLANK=2) -> 1024 beats; frame_end_out at k+1088, last mem_addr=1023.

Source files
------------

// File: rtl/pix_stream_tx.sv
// Frame-buffer reader: walks a raster image out of a synchronous-read SRAM and
// emits it as a framed pixel stream (ena / frame_start / line_start / frame_end).
module pix_stream_tx #(
    parameter int IMA    = 8,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int HBLANK = 2,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [IMA-1:0]    mem_data,
    output logic [IMA-1:0]    ima,
    output logic              ena_out,
    output logic              frame_start_out,
    output logic              line_start_out,
    output logic              frame_end_out,
    output logic              busy,
    output logic              done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int BW = (HBLANK > 1) ? $clog2(HBLANK) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FSTART,
        S_ACTIVE,
        S_HBLANK,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BW-1:0]     blank_q, blank_d;

    // Output pipe: one stage, lined up with the SRAM read latency.
    logic              ena_q, ena_d;
    logic              ls_q, ls_d;
    logic              fe_q, fe_d;
    logic              fs_q, fs_d;
    logic              done_q, done_d;
    logic [IMA-1:0]    ima_q, ima_d;

    logic              last_col;
    logic              last_row;

    assign last_col = (col_q == CW'(IMG_W - 1));
    assign last_row = (row_q == RW'(IMG_H - 1));

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        addr_d  = addr_q;
        blank_d = blank_q;
        mem_rd  = 1'b0;
        ls_d    = 1'b0;
        fe_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // The idle cycle that carries done never accepts a start.
                if (start && !done_q) begin
                    state_d = S_FSTART;
                end
            end
            S_FSTART: begin
                col_d   = '0;
                row_d   = '0;
                addr_d  = '0;
                blank_d = '0;
                state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (!stall) begin
                    mem_rd = 1'b1;
                    ls_d   = (col_q == '0);
                    fe_d   = last_col && last_row;
                    addr_d = addr_q + 1'b1;
                    if (last_col) begin
                        col_d = '0;
                        if (last_row) begin
                            state_d = S_DONE;
                        end else begin
                            row_d   = row_q + 1'b1;
                            blank_d = '0;
                            state_d = (HBLANK == 0) ? S_ACTIVE : S_HBLANK;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_HBLANK: begin
                if (blank_q == BW'(HBLANK - 1)) begin
                    blank_d = '0;
                    state_d = S_ACTIVE;
                end else begin
                    blank_d = blank_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ena_d  = mem_rd;
        fs_d   = (state_q == S_FSTART);
        done_d = fe_q;
        // Read data lands while its tag is in the pipe; pass it through then, hold otherwise.
        ima_d  = ena_q ? mem_data : ima_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            blank_q <= '0;
            ena_q   <= 1'b0;
            ls_q    <= 1'b0;
            fe_q    <= 1'b0;
            fs_q    <= 1'b0;
            done_q  <= 1'b0;
            ima_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            blank_q <= blank_d;
            ena_q   <= ena_d;
            ls_q    <= ls_d;
            fe_q    <= fe_d;
            fs_q    <= fs_d;
            done_q  <= done_d;
            ima_q   <= ima_d;
        end
    end

    assign mem_addr        = addr_q;
    assign ima             = ima_d;
    assign ena_out         = ena_q;
    assign line_start_out  = ls_q;
    assign frame_end_out   = fe_q;
    assign frame_start_out = fs_q;
    assign done            = done_q;
    assign busy            = (state_q != S_IDLE) || ena_q;

endmodule

// File: tb/tb_pix_stream_tx.sv
// Bench for pix_stream_tx: three instances (4x3/HBLANK=2, 4x3/HBLANK=0, 32x32/HBLANK=2)
// share start/stall; a pixel-index model checks every cycle, a scenario table checks timing.
module tb_pix_stream_tx;
    localparam int ND = 3;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic stall = 1'b0;

    always #5 clk = ~clk;

    logic [ND-1:0]         mem_rd_o, ena_o, fs_o, ls_o, fe_o, busy_o, done_o;
    logic [ND-1:0][AW-1:0] mem_addr_o;
    logic [ND-1:0][7:0]    ima_o;

    function automatic logic [7:0] pix_val(input logic [9:0] a);
        return a[7:0] ^ {4{a[9:8]}};
    endfunction

    for (genvar gi = 0; gi < ND; gi++) begin : g_dut
        logic [7:0] mem_q;
        always @(posedge clk) begin
            if (mem_rd_o[gi]) mem_q <= pix_val(mem_addr_o[gi]);
        end
        pix_stream_tx #(
            .IMA   (8),
            .IMG_W ((gi == 2) ? 32 : 4),
            .IMG_H ((gi == 2) ? 32 : 3),
            .HBLANK((gi == 1) ? 0 : 2),
            .ADDR_W(AW)
        ) u_dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .start          (start),
            .stall          (stall),
            .mem_rd         (mem_rd_o[gi]),
            .mem_addr       (mem_addr_o[gi]),
            .mem_data       (mem_q),
            .ima            (ima_o[gi]),
            .ena_out        (ena_o[gi]),
            .frame_start_out(fs_o[gi]),
            .line_start_out (ls_o[gi]),
            .frame_end_out  (fe_o[gi]),
            .busy           (busy_o[gi]),
            .done           (done_o[gi])
        );
    end

    int cfg_w  [ND] = '{4, 4, 32};
    int cfg_h  [ND] = '{3, 3, 32};
    int cfg_hb [ND] = '{2, 0, 2};

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: 0 idle, 1 frame-start cycle, 2 streaming, 3 closing cycle.
    int m_st [ND];
    int m_p  [ND];
    int m_gap[ND];
    logic       exp_ena[ND], exp_fs[ND], exp_ls[ND], exp_fe[ND], exp_done[ND], exp_busy[ND];
    logic [7:0] exp_ima[ND];

    int ev_base;
    int ev_fs1[ND], ev_fs2[ND], ev_fe[ND], ev_done[ND], ev_beats[ND], ev_addr0[ND];

    task automatic chk(input string name, input int d, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s dut%0d cyc=%0d: got %0d, expected %0d", name, d, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            m_st[d] = 0; m_p[d] = 0; m_gap[d] = 0;
            exp_ena[d] = 0; exp_fs[d] = 0; exp_ls[d] = 0; exp_fe[d] = 0;
            exp_done[d] = 0; exp_busy[d] = 0; exp_ima[d] = 8'h00;
        end
    endtask

    task automatic clr_ev();
        ev_base = cyc;
        for (int d = 0; d < ND; d++) begin
            ev_fs1[d] = -1; ev_fs2[d] = -1; ev_fe[d] = -1; ev_done[d] = -1;
            ev_beats[d] = 0; ev_addr0[d] = -1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            chk("rst_ena",  d, int'(ena_o[d]),      0);
            chk("rst_fs",   d, int'(fs_o[d]),       0);
            chk("rst_ls",   d, int'(ls_o[d]),       0);
            chk("rst_fe",   d, int'(fe_o[d]),       0);
            chk("rst_done", d, int'(done_o[d]),     0);
            chk("rst_busy", d, int'(busy_o[d]),     0);
            chk("rst_rd",   d, int'(mem_rd_o[d]),   0);
            chk("rst_addr", d, int'(mem_addr_o[d]), 0);
            chk("rst_ima",  d, int'(ima_o[d]),      0);
        end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // One clock: compare outputs, drive inputs, check the read port, advance the model.
    task automatic step(input logic st_in, input logic sl_in);
        logic issue;
        logic n_ena, n_ls, n_fe, n_fs, n_done;
        logic [7:0] n_ima;
        int w, n;
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk("ena",   d, int'(ena_o[d]),  int'(exp_ena[d]));
            chk("fs",    d, int'(fs_o[d]),   int'(exp_fs[d]));
            chk("ls",    d, int'(ls_o[d]),   int'(exp_ls[d]));
            chk("fe",    d, int'(fe_o[d]),   int'(exp_fe[d]));
            chk("done",  d, int'(done_o[d]), int'(exp_done[d]));
            chk("busy",  d, int'(busy_o[d]), int'(exp_busy[d]));
            chk("ima",   d, int'(ima_o[d]),  int'(exp_ima[d]));
            if (fs_o[d]) begin
                if (ev_fs1[d] < 0) ev_fs1[d] = cyc - ev_base;
                else if (ev_fs2[d] < 0) ev_fs2[d] = cyc - ev_base;
            end
            if (ena_o[d] && ev_done[d] < 0) ev_beats[d]++;
            if (fe_o[d] && ev_fe[d] < 0) ev_fe[d] = cyc - ev_base;
            if (done_o[d] && ev_done[d] < 0) ev_done[d] = cyc - ev_base;
        end
        start = st_in;
        stall = sl_in;
        #1;
        for (int d = 0; d < ND; d++) begin
            w = cfg_w[d];
            n = cfg_w[d] * cfg_h[d];
            issue = (m_st[d] == 2) && (m_gap[d] == 0) && !stall;
            chk("mem_rd", d, int'(mem_rd_o[d]), int'(issue));
            if (issue) chk("mem_addr", d, int'(mem_addr_o[d]), m_p[d]);
            if (mem_rd_o[d] && ev_addr0[d] < 0) ev_addr0[d] = int'(mem_addr_o[d]);

            n_ena = 0; n_ls = 0; n_fe = 0;
            n_fs = (m_st[d] == 1);
            n_done = exp_fe[d];
            n_ima = exp_ima[d];
            case (m_st[d])
                0: if (start && !exp_done[d]) m_st[d] = 1;
                1: begin m_st[d] = 2; m_p[d] = 0; m_gap[d] = 0; end
                2: begin
                    if (m_gap[d] > 0) begin
                        m_gap[d]--;
                    end else if (!stall) begin
                        n_ena = 1;
                        n_ima = pix_val(10'(m_p[d]));
                        n_ls = (m_p[d] % w == 0);
                        n_fe = (m_p[d] == n - 1);
                        m_p[d]++;
                        if (m_p[d] == n) m_st[d] = 3;
                        else if (m_p[d] % w == 0) m_gap[d] = cfg_hb[d];
                    end
                end
                default: m_st[d] = 0;
            endcase
            exp_ena[d] = n_ena; exp_ls[d] = n_ls; exp_fe[d] = n_fe; exp_fs[d] = n_fs;
            exp_done[d] = n_done; exp_ima[d] = n_ima;
            exp_busy[d] = (m_st[d] != 0) || n_ena;
        end
        cyc++;
    endtask

    typedef struct {
        string name;
        int dut;
        int stall_at;
        int stall_len;
        int restart_at;
        bit hold;
        int exp_fs;
        int exp_fe;
        int exp_done;
        int exp_beats;
        int exp_fs2;
        int run_len;
    } scen_t;

    scen_t scen[6];

    initial begin
        scen[0] = '{"plain",    0, -1, 0, -1, 1'b0, 2, 18,   19,   12,   -1, 40};
        scen[1] = '{"stall3",   0,  9, 3, -1, 1'b0, 2, 21,   22,   12,   -1, 40};
        scen[2] = '{"hblank0",  1, -1, 0, -1, 1'b0, 2, 14,   15,   12,   -1, 40};
        scen[3] = '{"restart",  0, -1, 0, 10, 1'b0, 2, 18,   19,   12,   -1, 40};
        scen[4] = '{"hold",     0, -1, 0, -1, 1'b1, 2, 18,   19,   12,   22, 40};
        scen[5] = '{"full32",   2, -1, 0, -1, 1'b0, 2, 1088, 1089, 1024, -1, 1100};

        model_reset();
        clr_ev();
        do_reset();

        for (int s = 0; s < 6; s++) begin
            logic st_v, sl_v;
            do_reset();
            clr_ev();
            for (int i = 0; i < scen[s].run_len; i++) begin
                st_v = (i == 0) || scen[s].hold || (i == scen[s].restart_at);
                sl_v = (i >= scen[s].stall_at) && (i < scen[s].stall_at + scen[s].stall_len);
                step(st_v, sl_v);
            end
            chk({scen[s].name, "_fs"},    scen[s].dut, ev_fs1[scen[s].dut],   scen[s].exp_fs);
            chk({scen[s].name, "_fe"},    scen[s].dut, ev_fe[scen[s].dut],    scen[s].exp_fe);
            chk({scen[s].name, "_done"},  scen[s].dut, ev_done[scen[s].dut],  scen[s].exp_done);
            chk({scen[s].name, "_beats"}, scen[s].dut, ev_beats[scen[s].dut], scen[s].exp_beats);
            chk({scen[s].name, "_fs2"},   scen[s].dut, ev_fs2[scen[s].dut],   scen[s].exp_fs2);
            $display("scenario %s: fs=%0d fe=%0d done=%0d beats=%0d fs2=%0d", scen[s].name,
                     ev_fs1[scen[s].dut], ev_fe[scen[s].dut], ev_done[scen[s].dut],
                     ev_beats[scen[s].dut], ev_fs2[scen[s].dut]);
        end

        // Reset in the middle of line 2 aborts the frame; the next frame restarts at address 0.
        do_reset();
        clr_ev();
        step(1'b1, 1'b0);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0);
        do_reset();
        clr_ev();
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0);
        chk("abort_no_fe",   0, ev_fe[0],   -1);
        chk("abort_no_done", 0, ev_done[0], -1);
        clr_ev();
        step(1'b1, 1'b0);
        for (int i = 0; i < 24; i++) step(1'b0, 1'b0);
        chk("restart_addr0", 0, ev_addr0[0], 0);
        chk("restart_fe",    0, ev_fe[0],    18);
        $display("reset-abort: restart first addr=%0d fe=%0d", ev_addr0[0], ev_fe[0]);

        // Random start/stall traffic against the model.
        do_reset();
        clr_ev();
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
        end
        $display("random phase: %0d cycles", 4000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
